// File: rtl/conv14x14_ctrl.sv
// conv14x14_ctrl: sweeps a 14x14 image (196 pixels) through NUM_CORES 5x5
// kernels. It presents a pixel index (dPstate) and a kernel index (core_sel)
// to an external combinational datapath. It registers the datapath result
// (conv_in) into a valid/ready result port, one result per cycle when the
// consumer keeps up.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start, abort         begin a pass (taken in IDLE only) / cancel the pass
//   busy, done           pass in progress / one-cycle end-of-pass pulse
//   dPstate, core_sel    pixel and kernel index driven to the datapath
//   conv_in              datapath result for the current dPstate/core_sel
//   res_*                registered result (data, pixel, kernel, last flag)
//   res_valid/res_ready  result handshake
module conv14x14_ctrl #(
    parameter int NUM_CORES = 4,
    parameter int IntSize   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [20:0]        dPstate,
    output logic [2:0]         core_sel,
    input  logic [IntSize-1:0] conv_in,
    output logic [IntSize-1:0] res_data,
    output logic [7:0]         res_pix,
    output logic [2:0]         res_core,
    output logic               res_last,
    output logic               res_valid,
    input  logic               res_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [IntSize-1:0] data;
        logic [7:0]         pix;
        logic [2:0]         core;
        logic               last;
    } res_t;

    localparam logic [7:0] LAST_PIX  = 8'd195;
    localparam logic [2:0] LAST_CORE = 3'(NUM_CORES - 1);

    state_t     state;
    res_t       res;
    logic [7:0] pix;
    logic       load;
    logic       pix_end;
    logic       core_end;

    // The output register can take a new result when it is empty or being drained.
    assign load     = !res_valid || res_ready;
    assign pix_end  = (pix == LAST_PIX);
    assign core_end = (core_sel == LAST_CORE);

    assign dPstate  = {13'd0, pix};
    assign res_data = res.data;
    assign res_pix  = res.pix;
    assign res_core = res.core;
    assign res_last = res.last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix       <= 8'd0;
            core_sel  <= 3'd0;
            res       <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (res_valid && res_ready)
                        res_valid <= 1'b0;
                    if (start) begin
                        pix      <= 8'd0;
                        core_sel <= 3'd0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        pix       <= 8'd0;
                        core_sel  <= 3'd0;
                        res_valid <= 1'b0;
                        res.last  <= 1'b0;
                    end else if (load) begin
                        res.data  <= conv_in;
                        res.pix   <= pix;
                        res.core  <= core_sel;
                        res.last  <= pix_end && core_end;
                        res_valid <= 1'b1;
                        if (pix_end) begin
                            pix <= 8'd0;
                            // Final kernel: hold core_sel and wait for the
                            // last result to be taken.
                            if (core_end)
                                state <= DRAIN;
                            else
                                core_sel <= core_sel + 3'd1;
                        end else begin
                            pix <= pix + 8'd1;
                        end
                    end
                end

                DRAIN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        pix       <= 8'd0;
                        core_sel  <= 3'd0;
                        res_valid <= 1'b0;
                        res.last  <= 1'b0;
                    end else if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    // start is not sampled here, so a start coincident with
                    // done does not launch a pass.
                    done  <= 1'b0;
                    state <= IDLE;
                    if (res_valid && res_ready)
                        res_valid <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
